// File: rtl/ysyx_22041211_ifu_axi_fetch_pkg.sv
// ysyx_22041211_ifu_axi_fetch_pkg: FSM state encodings, AXI read response codes and the NOP word
// shared by the instruction-fetch AXI master.
package ysyx_22041211_ifu_axi_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADDR = 2'b01,
      DATA = 2'b10,
      RESP = 2'b11
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Anything other than a plain OKAY is reported to the IFU as a fetch error.
   function automatic logic resp_is_err(input logic [1:0] r);
      return r inside {RESP_EXOKAY, RESP_SLVERR, RESP_DECERR};
   endfunction

endpackage

// File: rtl/ysyx_22041211_ifu_axi_fetch.sv
// ysyx_22041211_ifu_axi_fetch: single-outstanding AXI4-Lite instruction fetch master with redirect kill.
// Define IFU_FETCH_ALIGN_CHECK_EN to answer misaligned pcs locally with a NOP plus error.
module ysyx_22041211_ifu_axi_fetch
   import ysyx_22041211_ifu_axi_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  flush_i,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_inst,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic                  rready
);

   state_t                state, state_n;
   logic                  kill, kill_n;
   logic                  arvalid_n, rready_n, resp_valid_n, resp_err_n;
   logic [ADDR_WIDTH-1:0] araddr_n;
   logic [DATA_WIDTH-1:0] resp_inst_n;
   logic                  misaligned;
   logic                  drop;

`ifdef IFU_FETCH_ALIGN_CHECK_EN
   assign misaligned = req_addr[1:0] != 2'b00;
`else
   assign misaligned = 1'b0;
`endif

   assign req_ready = (state == IDLE) & ~flush_i;
   // A flush arriving together with rvalid still kills that beat.
   assign drop = kill | flush_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         kill       <= 1'b0;
         arvalid    <= 1'b0;
         rready     <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         araddr     <= '0;
         resp_inst  <= '0;
      end else begin
         state      <= state_n;
         kill       <= kill_n;
         arvalid    <= arvalid_n;
         rready     <= rready_n;
         resp_valid <= resp_valid_n;
         resp_err   <= resp_err_n;
         araddr     <= araddr_n;
         resp_inst  <= resp_inst_n;
      end
   end

   always_comb begin
      state_n      = state;
      kill_n       = kill;
      arvalid_n    = arvalid;
      rready_n     = rready;
      resp_valid_n = resp_valid;
      resp_err_n   = resp_err;
      araddr_n     = araddr;
      resp_inst_n  = resp_inst;
      case (state)
         IDLE: begin
            if (req_valid & req_ready) begin
               if (misaligned) begin
                  resp_valid_n = 1'b1;
                  resp_err_n   = 1'b1;
                  resp_inst_n  = DATA_WIDTH'(NOP_INST);
                  state_n      = RESP;
               end else begin
                  araddr_n  = req_addr;
                  arvalid_n = 1'b1;
                  state_n   = ADDR;
               end
            end
         end
         ADDR: begin
            kill_n = drop;
            if (arready) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               state_n   = DATA;
            end
         end
         DATA: begin
            kill_n = drop;
            if (rvalid) begin
               rready_n = 1'b0;
               if (drop) begin
                  kill_n  = 1'b0;
                  state_n = IDLE;
               end else begin
                  resp_inst_n  = rdata;
                  resp_err_n   = resp_is_err(rresp);
                  resp_valid_n = 1'b1;
                  state_n      = RESP;
               end
            end
         end
         default: begin
            if (resp_ready | flush_i) begin
               resp_valid_n = 1'b0;
               state_n      = IDLE;
            end
         end
      endcase
   end

endmodule

// File: doc/ysyx_22041211_ifu_axi_fetch.md
Name: ysyx_22041211_ifu_axi_fetch

Overview:
Instruction-fetch bus master directly upstream of the IFU. It takes the IFU fetch request (ce pulse plus pc) and issues one AXI4-Lite read on the AR/R channels. It returns the instruction word to the IFU's inst_i path with a valid/ready handshake. One transaction is outstanding at most, and a redirect flush discards stale responses.

Parameters:
ADDR_WIDTH, 32, fetch address / araddr width
DATA_WIDTH, 32, instruction / rdata width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  fetch request (driven by IFU ce)
req_ready  out  1  request accepted this cycle
req_addr  in  ADDR_WIDTH  fetch pc
flush_i  in  1  redirect (branch/jmp/csr); kill in-flight fetch
resp_valid  out  1  instruction available
resp_ready  in  1  IFU consumes instruction
resp_inst  out  DATA_WIDTH  fetched instruction
resp_err  out  1  bus/alignment error for this fetch
araddr  out  ADDR_WIDTH  AXI read address
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
rdata  in  DATA_WIDTH  AXI read data
rresp  in  2  AXI read response
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready

Behaviour:
- Reset (rst=0, async): state IDLE; arvalid, rready, resp_valid, resp_err, kill flag = 0; araddr, resp_inst = 0. Any in-flight AXI transaction is abandoned because reset is global.
- States: IDLE, ADDR, DATA, RESP. All outputs are registered or decoded from state only; there is no combinational path from AXI inputs to IFU outputs.
- IDLE: req_ready = ~flush_i. On req_valid & req_ready, latch req_addr into araddr, set arvalid, and go to ADDR.
- ADDR: araddr and arvalid are held stable until arready. On arvalid & arready, clear arvalid, set rready, and go to DATA.
- DATA: rready=1. On rvalid, clear rready.
  - If kill=0: latch resp_inst=rdata, resp_err=(rresp!=2'b00), set resp_valid, and go to RESP.
  - If kill=1: discard the data, clear kill, and go to IDLE.
- RESP: resp_valid and resp_inst are held until resp_ready; on handshake, clear resp_valid and go to IDLE.
- Minimum latency: request accepted in cycle 0 → arvalid in cycle 1 → (arready in cycle 1) → rvalid in cycle 2 → resp_valid in cycle 3.
- flush_i rules:
  - IDLE: blocks acceptance that cycle.
  - ADDR/DATA: sets kill. The AXI transaction still completes; its data is dropped.
  - RESP: clears resp_valid next cycle and returns to IDLE.
  - flush_i with rvalid in the same DATA cycle: data dropped.
- req_valid outside IDLE is ignored; the IFU must re-present it after req_ready.
- resp_err=1: resp_inst carries rdata unchanged; the IFU or trap logic decides the action.
- Back-to-back: the RESP→IDLE→accept sequence costs one bubble cycle; this is accepted.

Optional Feature:
Macro IFU_FETCH_ALIGN_CHECK_EN.
- Defined: in IDLE, a request with req_addr[1:0]!=0 generates no AXI transaction. The next cycle gives RESP with resp_err=1 and resp_inst=32'h0000_0013 (NOP).
- Undefined: address bits are not checked; every request goes to AXI as-is.

Decomposition:
- Shared define file: state encodings (2-bit IDLE=00, ADDR=01, DATA=10, RESP=11); AXI resp codes OKAY=00, SLVERR=10, DECERR=11; NOP encoding 32'h0000_0013.
- No sub-module. A single FSM module is the natural granularity; the alignment check is a one-line decode inside the ifdef.

Test Plan:
1. Reset release, req_addr=32'h8000_0000, slave with arready=1 and rvalid one cycle later, rdata=32'h0010_0093 → resp_valid at cycle 3, resp_inst=32'h0010_0093, resp_err=0.
2. Slave holds arready=0 for 4 cycles → araddr and arvalid stay constant for all 4 cycles; no resp_valid before the R handshake.
3. flush_i pulsed in DATA, then rvalid with rdata=32'hDEAD_BEEF → no resp_valid; state back to IDLE; next request at 32'h8000_0100 returns its own data.
4. rresp=2'b10 with rdata=32'h0000_0000 → resp_valid=1, resp_err=1. resp_ready held low 5 cycles → outputs stable until the handshake.
5. rst driven low mid-DATA → arvalid, rready and resp_valid are 0 immediately, without waiting for a clock edge; after release, req_ready=1.
6. With IFU_FETCH_ALIGN_CHECK_EN, req_addr=32'h8000_0002 → arvalid never asserted; resp_valid next cycle with resp_err=1 and resp_inst=32'h0000_0013.
